// File: rtl/tia_hcount_pkg.sv
// Shared definitions for the TIA 6-bit horizontal polynomial counter.
// Also used by the object position counters, which run the same LFSR.
package tia_hcount_pkg;

    localparam int HCNT_W = 6;

    typedef logic [HCNT_W-1:0] hcnt_t;

    // Phase counter values; strobes are decoded from PH_PHI1 and PH_PHI2.
    typedef enum logic [1:0] {
        PH_PHI1 = 2'd0,
        PH_GAP1 = 2'd1,
        PH_PHI2 = 2'd2,
        PH_GAP2 = 2'd3
    } ph_t;

    localparam hcnt_t HSYNC_SET  = 6'b001111;  // count 4
    localparam hcnt_t HSYNC_CLR  = 6'b111011;  // count 8
    localparam hcnt_t HBLANK_CLR = 6'b011101;  // count 17
    localparam hcnt_t TERMINAL   = 6'b001010;  // count 56
    localparam hcnt_t LOCKUP     = 6'b111111;

    function automatic hcnt_t lfsr6_next(input hcnt_t s);
        return {s[4:0], ~(s[5] ^ s[4])};
    endfunction

endpackage

// File: rtl/tia_phase_gen.sv
// Divide-by-4 phase counter producing the two-phase strobes hphi1/hphi2.
// rsyn and reset both park the counter at the hphi1 phase.
module tia_phase_gen
    import tia_hcount_pkg::*;
(
    input  logic       clk,
    input  logic       rst_l,
    input  logic       rsyn,
    output logic [1:0] ph,
    output logic       hphi1,
    output logic       hphi2
);

    ph_t ph_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_l || rsyn) begin
            ph_q <= PH_PHI1;
        end else begin
            ph_q <= ph_t'(ph_q + 2'd1);
        end
    end

    assign ph    = ph_q;
    assign hphi1 = (ph_q == PH_PHI1);
    assign hphi2 = (ph_q == PH_PHI2);

endmodule

// File: rtl/tia_horiz_sync_counter.sv
// Horizontal timing source: phase strobes, 57-state polynomial line counter
// and the registered HSYNC / HBLANK / line-end decodes.
module tia_horiz_sync_counter
    import tia_hcount_pkg::*;
(
    input  logic       clk,
    input  logic       rst_l,
    input  logic       rsyn,
    output logic       hphi1,
    output logic       hphi2,
    output logic [5:0] hcnt,
    output logic       hsync,
    output logic       hblank,
    output logic       line_end
);

    logic [1:0] ph;
    hcnt_t      hcnt_q;
    hcnt_t      hcnt_nxt;
    logic       wrap;
    logic       advance;
    logic       hsync_q;
    logic       hblank_q;
    logic       line_end_q;

    tia_phase_gen u_phase_gen (
        .clk   (clk),
        .rst_l (rst_l),
        .rsyn  (rsyn),
        .ph    (ph),
        .hphi1 (hphi1),
        .hphi2 (hphi2)
    );

    // The counter advances on the edge that ends the hphi2 cycle.
    assign advance = (ph == PH_PHI2);

    // NOTE: every output of this block is assigned on all paths, so no latch is inferred.
    always_comb begin
        wrap     = (hcnt_q == TERMINAL) || (hcnt_q == LOCKUP);
        hcnt_nxt = wrap ? hcnt_t'(0) : lfsr6_next(hcnt_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_l || rsyn) begin
            hcnt_q     <= '0;
            hsync_q    <= 1'b0;
            hblank_q   <= 1'b1;
            line_end_q <= 1'b0;
        end else begin
            line_end_q <= 1'b0;
            if (advance) begin
                hcnt_q <= hcnt_nxt;
                if (wrap) begin
                    hblank_q   <= 1'b1;
                    line_end_q <= 1'b1;
                end
                if (hcnt_nxt == HSYNC_SET)  hsync_q  <= 1'b1;
                if (hcnt_nxt == HSYNC_CLR)  hsync_q  <= 1'b0;
                if (hcnt_nxt == HBLANK_CLR) hblank_q <= 1'b0;
            end
        end
    end

    assign hcnt     = hcnt_q;
    assign hsync    = hsync_q;
    assign hblank   = hblank_q;
    assign line_end = line_end_q;

endmodule

// File: tb/tb_tia_horiz_sync_counter.sv
// Self-checking bench for tia_horiz_sync_counter: directed timing scenarios
// plus randomized rsyn/reset traffic against a line-position reference model.
module tb_tia_horiz_sync_counter;

    logic       clk = 1'b0;
    logic       rst_l = 1'b0;
    logic       rsyn = 1'b0;
    logic       hphi1;
    logic       hphi2;
    logic [5:0] hcnt;
    logic       hsync;
    logic       hblank;
    logic       line_end;

    int checks = 0;
    int failures = 0;

    // Model: n = edges since the last reset/rsyn; everything derives from n.
    int         n = 0;
    logic [5:0] seq [57];

    tia_horiz_sync_counter dut (
        .clk      (clk),
        .rst_l    (rst_l),
        .rsyn     (rsyn),
        .hphi1    (hphi1),
        .hphi2    (hphi2),
        .hcnt     (hcnt),
        .hsync    (hsync),
        .hblank   (hblank),
        .line_end (line_end)
    );

    always #5 clk = ~clk;

    function automatic int pos();
        return ((n + 1) / 4) % 57;
    endfunction

    function automatic logic [10:0] model_vec();
        logic       e_phi1, e_phi2, e_sync, e_blank, e_le;
        e_phi1  = (n % 4 == 0);
        e_phi2  = (n % 4 == 2);
        e_sync  = (pos() >= 4) && (pos() < 8);
        e_blank = (pos() < 17);
        e_le    = (n % 4 == 3) && (pos() == 0) && (n > 0);
        return {e_phi1, e_phi2, seq[pos()], e_sync, e_blank, e_le};
    endfunction

    function automatic logic [10:0] dut_vec();
        return {hphi1, hphi2, hcnt, hsync, hblank, line_end};
    endfunction

    task automatic step(input logic r, input logic s);
        rst_l = r;
        rsyn  = s;
        @(posedge clk);
        if (!r || s) n = 0;
        else         n = n + 1;
        #1;
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        checks++;
        if (dut_vec() !== 11'b1_0_000000_0_1_0) begin
            failures++;
            $display("FAIL reset_state: got %b expected %b", dut_vec(), 11'b1_0_000000_0_1_0);
        end
    endtask

    task automatic test_phases();
        logic [5:0] e_h;
        for (int e = 1; e <= 8; e++) begin
            step(1'b1, 1'b0);
            e_h = (e < 3) ? 6'b000000 : (e < 7) ? 6'b000001 : 6'b000011;
            checks++;
            if (hphi1 !== (e % 4 == 0) || hphi2 !== (e % 4 == 2)) begin
                failures++;
                $display("FAIL phase_strobes edge %0d: got phi1=%b phi2=%b", e, hphi1, hphi2);
            end
            checks++;
            if (hcnt !== e_h) begin
                failures++;
                $display("FAIL phase_hcnt edge %0d: got %b expected %b", e, hcnt, e_h);
            end
        end
    endtask

    task automatic test_line_timing();
        int rise_e = -1, fall_e = -1, blank_e = -1;
        logic [5:0] rise_h = '0, fall_h = '0, blank_h = '0;
        logic p_sync, p_blank;
        step(1'b0, 1'b0);
        p_sync  = hsync;
        p_blank = hblank;
        for (int e = 1; e <= 228; e++) begin
            step(1'b1, 1'b0);
            if (!p_sync && hsync && rise_e < 0)   begin rise_e = e;  rise_h = hcnt;  end
            if (p_sync && !hsync && fall_e < 0)   begin fall_e = e;  fall_h = hcnt;  end
            if (p_blank && !hblank && blank_e < 0) begin blank_e = e; blank_h = hcnt; end
            p_sync  = hsync;
            p_blank = hblank;
        end
        checks++;
        if (rise_e != 15 || rise_h !== 6'b001111) begin
            failures++;
            $display("FAIL hsync_rise: edge %0d hcnt %b expected edge 15 hcnt 001111", rise_e, rise_h);
        end
        checks++;
        if (fall_e != 31 || fall_h !== 6'b111011) begin
            failures++;
            $display("FAIL hsync_fall: edge %0d hcnt %b expected edge 31 hcnt 111011", fall_e, fall_h);
        end
        checks++;
        if (blank_e != 67 || blank_h !== 6'b011101) begin
            failures++;
            $display("FAIL hblank_fall: edge %0d hcnt %b expected edge 67 hcnt 011101", blank_e, blank_h);
        end
    endtask

    task automatic test_two_lines();
        int le_edges[$];
        step(1'b0, 1'b0);
        for (int e = 1; e <= 460; e++) begin
            step(1'b1, 1'b0);
            if (line_end) le_edges.push_back(e);
            if (e == 226) begin
                checks++;
                if (hcnt !== 6'b001010) begin
                    failures++;
                    $display("FAIL terminal_state: got %b expected 001010", hcnt);
                end
            end
            if (e == 227) begin
                checks++;
                if ({hcnt, hblank, line_end} !== {6'b000000, 1'b1, 1'b1}) begin
                    failures++;
                    $display("FAIL wrap_edge: got hcnt=%b hblank=%b line_end=%b expected 000000 1 1",
                             hcnt, hblank, line_end);
                end
            end
            if (e == 228) begin
                checks++;
                if (line_end !== 1'b0) begin
                    failures++;
                    $display("FAIL line_end_width: got %b expected 0", line_end);
                end
            end
        end
        checks++;
        if (le_edges.size() != 2 || le_edges[0] != 227 || le_edges[1] != 455) begin
            failures++;
            $display("FAIL line_end_edges: got %0d pulses (first %0d) expected 227 and 455",
                     le_edges.size(), (le_edges.size() > 0) ? le_edges[0] : -1);
        end
    endtask

    task automatic test_rsyn_mid();
        int k = 0;
        int rise_e = -1;
        logic p_sync;
        step(1'b0, 1'b0);
        while (hcnt !== 6'b110101 && k < 300) begin
            step(1'b1, 1'b0);
            k++;
        end
        checks++;
        if (hcnt !== 6'b110101) begin
            failures++;
            $display("FAIL rsyn_mid_reach: got %b expected 110101 within 300 edges", hcnt);
        end
        step(1'b1, 1'b1);
        checks++;
        if ({hphi1, hcnt, hsync, hblank} !== {1'b1, 6'b000000, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL rsyn_mid_clear: got phi1=%b hcnt=%b hsync=%b hblank=%b expected 1 000000 0 1",
                     hphi1, hcnt, hsync, hblank);
        end
        p_sync = hsync;
        for (int e = 1; e <= 20; e++) begin
            step(1'b1, 1'b0);
            if (!p_sync && hsync && rise_e < 0) rise_e = e;
            p_sync = hsync;
        end
        checks++;
        if (rise_e != 15) begin
            failures++;
            $display("FAIL rsyn_hsync_rise: got edge %0d expected 15", rise_e);
        end
    endtask

    task automatic test_rsyn_wrap();
        int k = 0;
        step(1'b0, 1'b0);
        while (!(hcnt === 6'b001010 && hphi2 === 1'b1) && k < 300) begin
            step(1'b1, 1'b0);
            k++;
        end
        checks++;
        if (!(hcnt === 6'b001010 && hphi2 === 1'b1)) begin
            failures++;
            $display("FAIL rsyn_wrap_reach: got hcnt=%b phi2=%b expected 001010 1", hcnt, hphi2);
        end
        step(1'b1, 1'b1);
        checks++;
        if ({hcnt, line_end, hblank} !== {6'b000000, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL rsyn_wrap: got hcnt=%b line_end=%b hblank=%b expected 000000 0 1",
                     hcnt, line_end, hblank);
        end
        step(1'b1, 1'b0);
        checks++;
        if (line_end !== 1'b0) begin
            failures++;
            $display("FAIL rsyn_wrap_after: got line_end=%b expected 0", line_end);
        end
    endtask

    task automatic test_reset_mid_hsync();
        int k = 0;
        step(1'b0, 1'b0);
        while (hsync !== 1'b1 && k < 100) begin
            step(1'b1, 1'b0);
            k++;
        end
        checks++;
        if (hsync !== 1'b1) begin
            failures++;
            $display("FAIL hsync_reach: got %b expected 1 within 100 edges", hsync);
        end
        step(1'b0, 1'b0);
        checks++;
        if (dut_vec() !== 11'b1_0_000000_0_1_0) begin
            failures++;
            $display("FAIL reset_mid_hsync: got %b expected %b", dut_vec(), 11'b1_0_000000_0_1_0);
        end
    endtask

    task automatic test_random();
        logic r, s;
        step(1'b0, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 399) != 0);
            s = ($urandom_range(0, 149) == 0);
            step(r, s);
            checks++;
            if (dut_vec() !== model_vec()) begin
                failures++;
                $display("FAIL random cycle %0d (n=%0d): got %b expected %b", i, n, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_lockup();
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        force dut.hcnt_q = 6'b111111;
        #1;
        release dut.hcnt_q;
        #1;
        checks++;
        if (hcnt !== 6'b111111 || hphi2 !== 1'b1) begin
            failures++;
            $display("FAIL lockup_setup: got hcnt=%b phi2=%b expected 111111 1", hcnt, hphi2);
        end
        step(1'b1, 1'b0);
        checks++;
        if (hcnt !== 6'b000000) begin
            failures++;
            $display("FAIL lockup_recover: got %b expected 000000", hcnt);
        end
        step(1'b0, 1'b0);
    endtask

    initial begin
        seq[0] = 6'b000000;
        for (int i = 1; i < 57; i++)
            seq[i] = {seq[i-1][4:0], ~(seq[i-1][5] ^ seq[i-1][4])};

        test_reset();
        test_phases();
        test_line_timing();
        test_two_lines();
        test_rsyn_mid();
        test_rsyn_wrap();
        test_reset_mid_hsync();
        test_random();
        test_lockup();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tia_horiz_sync_counter.md
Name: tia_horiz_sync_counter

Overview:
Horizontal timing source for the TIA model. It divides the color clock by 4 into the two-phase strobes hphi1/hphi2, which the d1 delay cells downstream consume. It also runs the 6-bit horizontal polynomial counter, a 57-state LFSR giving 228 color clocks per line, and decodes HSYNC, HBLANK and line-end from it. It sits directly upstream of the d1 delay chain and object counters and replaces free-running biphase generation with a synchronous, single-clock version.

Parameters:
HSYNC_SET, 6'b001111, counter state whose entry raises hsync (count 4)
HSYNC_CLR, 6'b111011, counter state whose entry drops hsync (count 8)
HBLANK_CLR, 6'b011101, counter state whose entry drops hblank (count 17)
TERMINAL, 6'b001010, last state of the line (count 56); the next advance wraps to 0

Ports:
clk  in  1  color clock; all state updates on the rising edge
rst_l  in  1  synchronous reset, active-low
rsyn  in  1  RSYNC strobe, sampled at the clk edge
hphi1  out  1  phase-1 strobe, high 1 of every 4 clk cycles
hphi2  out  1  phase-2 strobe, high 1 of every 4 clk cycles, 2 cycles after hphi1
hcnt  out  6  current polynomial counter state
hsync  out  1  horizontal sync
hblank  out  1  horizontal blank
line_end  out  1  one-cycle pulse after the counter wraps

Behaviour:
- State
  - ph[1:0]: phase counter.
  - hcnt[5:0]: the LFSR.
  - hsync, hblank, line_end: registered outputs.
- Strobes: hphi1 = (ph==0), hphi2 = (ph==2). Both are decoded from registers only; never both high.
- Reset (rst_l=0 at an edge): ph=0, hcnt=6'b000000, hsync=0, hblank=1, line_end=0. Reset overrides everything.
- Each edge with rst_l=1 and rsyn=0: ph <= ph+1, mod 4.
- Advance edge is an edge where ph==2 (hphi2 high in the preceding cycle):
  - If hcnt==TERMINAL or hcnt==6'b111111: hcnt <= 0. The 111111 case is lockup recovery; it is unreachable from reset.
  - Otherwise: hcnt <= {hcnt[4:0], ~(hcnt[5]^hcnt[4])}.
- Flag updates on the same advance edge, based on the next hcnt value:
  - Next value 0 from a wrap: hblank <= 1, line_end <= 1.
  - Next value == HSYNC_SET: hsync <= 1.
  - Next value == HSYNC_CLR: hsync <= 0.
  - Next value == HBLANK_CLR: hblank <= 0.
- line_end clears on the following edge, so it is exactly 1 clk wide.
- hcnt, hsync and hblank hold on all non-advance edges.
- rsyn=1 at an edge (rst_l=1): ph <= 0, hcnt <= 0, hsync <= 0, hblank <= 1, line_end <= 0.
  - rsyn beats a simultaneous advance or wrap; no line_end is generated.
  - rsyn held high keeps the block in this state.
- Timing from reset/rsyn release, counting edge 1 as the first edge after release:
  - Advance k occurs at edge 4k-1.
  - hsync rises at edge 15 and falls at edge 31 (16 clks wide).
  - hblank falls at edge 67.
  - Wrap occurs at edge 227, so line_end is high in the cycle after edge 227.
  - Line period is 228 clk.
- Counter sequence from 0, per the feedback rule: 000000, 000001, 000011, 000111, 001111 (4), 011111, 111110, 111101, 111011 (8), … 011101 (17) … 001010 (56).

Decomposition:
- Shared package tia_hcount_pkg holds:
  - the 6-bit state width;
  - the TERMINAL, HSYNC_SET, HSYNC_CLR and HBLANK_CLR constants;
  - a function lfsr6_next(s) implementing the feedback rule.
- The same package is reused by the object position counters.
- One sub-module, tia_phase_gen, holds ph and drives hphi1/hphi2 from rsyn and rst_l. The LFSR and decodes stay in the top.

Test Plan:
- Reset release, 8 clk → hphi1 high at cycles 0 and 4, hphi2 at 2 and 6, never overlapping; hcnt=000000 until edge 3, then 000001; hcnt=000011 after edge 7.
- Run 228 clk from reset → hsync 0→1 at edge 15 and 1→0 at edge 31 with hcnt=111011; hblank 1→0 at edge 67 with hcnt=011101.
- Run 2 lines → hcnt=001010 just before edge 227; edge 227 gives hcnt=000000, hblank=1 and line_end=1 for exactly 1 cycle; the next line_end follows edge 455.
- Assert rsyn for 1 clk mid-line at hcnt=110101 → next cycle ph=0, hcnt=0, hsync=0, hblank=1; the hsync rise follows 15 edges later.
- Assert rsyn at the wrap edge (hcnt=001010, ph==2) → hcnt=0 and line_end stays 0.
- Apply rst_l=0 mid-hsync (hsync=1) → next cycle all outputs are at reset values; force hcnt=111111 via a backdoor → the next advance yields 000000.
